// File: rtl/instr_sequencer.sv
// Program-driven issuer of opcode/opr1/opr2 words for the instruction decoder.
// Define INSTR_SEQUENCER_STEP_MODE_EN to add single-step control (step_en/step, PAUSE state).
module instr_sequencer #(
  parameter int          PROG_DEPTH  = 16,
  parameter int          SLOT_CYCLES = 4,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  localparam int         AW          = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
  input  logic          step_en,
  input  logic          step,
`endif
  output logic [3:0]    opcode,
  output logic [3:0]    opr1,
  output logic [7:0]    opr2,
  output logic          issue_strobe,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [15:0]   instr_count
);

  localparam int            CW      = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);

  // Valid/ready: none. start/stop/step are level-sampled on each rising edge;
  // issue_strobe marks the first cycle a new word is presented, and the word
  // stays stable until the next strobe (or reset).
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HOLD,
    S_DONE
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
    , S_PAUSE
`endif
  } state_t;

  state_t        state;
  logic [15:0]   mem [PROG_DEPTH];
  logic [15:0]   word_q;
  logic [CW-1:0] slot_cnt;
  logic          stop_q;
  logic          slot_end;
  logic          in_slot;
  logic [AW-1:0] next_pc;

  // Writes only land while no program is running.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_DONE))
      mem[prog_addr] <= prog_wdata;
  end

  always_comb begin
    slot_end = 1'b0;
    if (state == S_ISSUE && SLOT_CYCLES == 1)
      slot_end = 1'b1;
    if (state == S_HOLD && slot_cnt == '0)
      slot_end = 1'b1;
    in_slot = (state == S_FETCH) || (state == S_ISSUE) || (state == S_HOLD);
    next_pc = (pc == LAST_PC) ? '0 : pc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      opcode       <= '0;
      opr1         <= '0;
      opr2         <= '0;
      issue_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pc           <= '0;
      instr_count  <= '0;
      word_q       <= '0;
      slot_cnt     <= '0;
      stop_q       <= 1'b0;
    end else begin
      issue_strobe <= 1'b0;

      if (state == S_ISSUE) begin
        opcode       <= word_q[15:12];
        opr1         <= word_q[11:8];
        opr2         <= word_q[7:0];
        issue_strobe <= 1'b1;
        if (instr_count != 16'hFFFF)
          instr_count <= instr_count + 16'd1;
        slot_cnt <= CW'(SLOT_CYCLES - 2);
      end else if (state == S_HOLD && slot_cnt != '0) begin
        slot_cnt <= slot_cnt - 1'b1;
      end

      // A stop seen anywhere in the slot is honoured once the slot finishes.
      if (in_slot)
        stop_q <= stop_q | stop;

      if (slot_end) begin
        if (stop_q || stop) begin
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          stop_q <= 1'b0;
        end else if (pc == LAST_PC && !loop_en) begin
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          stop_q <= 1'b0;
        end else begin
          pc <= next_pc;
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
          state <= step_en ? S_PAUSE : S_FETCH;
`else
          state <= S_FETCH;
`endif
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start && !stop) begin
              pc          <= '0;
              instr_count <= '0;
              done        <= 1'b0;
              busy        <= 1'b1;
              stop_q      <= 1'b0;
              state       <= S_FETCH;
            end
          end
          S_FETCH: begin
            // A halt word ends the run without touching the issued fields.
            if (mem[pc][15:12] == HALT_OPCODE) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              stop_q <= 1'b0;
            end else begin
              word_q <= mem[pc];
              state  <= S_ISSUE;
            end
          end
          S_ISSUE: state <= S_HOLD;
          S_HOLD:  state <= S_HOLD;
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
          S_PAUSE: begin
            if (stop) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              stop_q <= 1'b0;
            end else if (step) begin
              state <= S_FETCH;
            end
          end
`endif
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: randomized programs checked against a behavioural
// program-walk model (expected issue list, strobe cycles, final pc/count).
module tb_instr_sequencer;

  localparam int         DEPTH  = 16;
  localparam int         SLOT   = 4;
  localparam int         PERIOD = SLOT + 1;
  localparam logic [3:0] HALT   = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        start;
  logic        stop;
  logic        loop_en;
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
  logic        step_en;
  logic        step;
`endif
  logic [3:0]  opcode;
  logic [3:0]  opr1;
  logic [7:0]  opr2;
  logic        issue_strobe;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [15:0] instr_count;

  instr_sequencer #(.PROG_DEPTH(DEPTH), .SLOT_CYCLES(SLOT), .HALT_OPCODE(HALT)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .stop(stop), .loop_en(loop_en),
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
    .step_en(step_en), .step(step),
`endif
    .opcode(opcode), .opr1(opr1), .opr2(opr2), .issue_strobe(issue_strobe),
    .busy(busy), .done(done), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q [$];
  logic [15:0] last_out = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = 4'(addr);
    prog_wdata = data;
    @(negedge clk);
    prog_we = 1'b0;
    model_mem[addr] = data;
  endtask

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == HALT)
      w[15:12] = 4'($urandom_range(0, 14));
    if (allow_halt && $urandom_range(0, 5) == 0)
      w[15:12] = HALT;
    return w;
  endfunction

  // Walk the program as the decoder would see it, then watch the DUT cycle by cycle.
  task automatic run_prog(input bit loop, input int stop_at, input bit busy_wr, input string name);
    int          n = 0, p = 0, seen = 0, k, k_stop = -1, done_k;
    bit          by_halt = 0;
    logic [15:0] w, lastw;
    exp_q.delete();
    lastw = last_out;
    forever begin
      w = model_mem[p];
      if (w[15:12] == HALT) begin by_halt = 1; break; end
      exp_q.push_back(w);
      lastw = w;
      n++;
      if (stop_at != 0 && n == stop_at) break;
      if (p == DEPTH - 1 && !loop) break;
      p = (p + 1) % DEPTH;
    end
    done_k = (n == 0) ? 1 : 3 + PERIOD * (n - 1) + (by_halt ? SLOT : SLOT - 1);

    loop_en = loop;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k <= done_k + 3) begin
      if (issue_strobe) begin
        if (exp_q.size() == 0) begin
          check_eq({name, " extra_strobe"}, 32'(k), 32'(done_k));
        end else begin
          w = exp_q.pop_front();
          check_eq({name, " word"}, {16'h0, opcode, opr1, opr2}, {16'h0, w});
          check_eq({name, " strobe_cycle"}, 32'(k), 32'(3 + PERIOD * seen));
          seen++;
          if (seen == stop_at) k_stop = k + 1;
        end
      end
      if (k == done_k - 1)
        check_eq({name, " done_early"}, {31'h0, done}, 32'h0);
      if (k == done_k) begin
        check_eq({name, " done"}, {31'h0, done}, 32'h1);
        check_eq({name, " busy_at_done"}, {31'h0, busy}, 32'h0);
        check_eq({name, " instr_count"}, {16'h0, instr_count}, 32'(n));
        check_eq({name, " pc"}, {28'h0, pc}, 32'(p));
        check_eq({name, " held_fields"}, {16'h0, opcode, opr1, opr2}, {16'h0, lastw});
      end
      stop = (k == k_stop);
      if (busy_wr && k == 2) begin
        prog_we    = 1'b1;
        prog_addr  = 4'd1;
        prog_wdata = 16'h9999;
      end else begin
        prog_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    stop    = 1'b0;
    prog_we = 1'b0;
    check_eq({name, " missing_strobes"}, 32'(exp_q.size()), 32'h0);
    last_out = lastw;
  endtask

  initial begin
    int  k;
    bit  any_strobe;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
`ifdef INSTR_SEQUENCER_STEP_MODE_EN
    step_en = 1'b0; step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset fields", {16'h0, opcode, opr1, opr2}, 32'h0);
    check_eq("reset flags", {29'h0, issue_strobe, busy, done}, 32'h0);
    check_eq("reset pc_count", {12'h0, pc, instr_count}, 32'h0);
    rst = 1'b0;

    // start and stop together: stop wins, nothing runs
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    any_strobe = 0;
    repeat (6) begin @(negedge clk); any_strobe |= issue_strobe | busy; end
    check_eq("start_stop idle", {31'h0, any_strobe}, 32'h0);
    check_eq("start_stop done", {31'h0, done}, 32'h0);

    write_word(0, 16'h0203);
    write_word(1, 16'h2100);
    write_word(2, 16'hF000);
    run_prog(0, 0, 0, "halt_prog");

    write_word(0, 16'h1234);
    for (int i = 1; i < DEPTH; i++) write_word(i, rand_word(0));
    run_prog(0, 0, 0, "full_prog");
    run_prog(1, 20, 0, "loop_stop");
    run_prog(0, 0, 1, "busy_write");
    run_prog(0, 0, 0, "rerun");

    // asynchronous reset in the middle of a slot
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!issue_strobe && k < 20) begin @(negedge clk); k++; end
    check_eq("mid_rst strobe_seen", {31'h0, issue_strobe}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst fields", {16'h0, opcode, opr1, opr2}, 32'h0);
    check_eq("mid_rst count_busy", {15'h0, instr_count, busy}, 32'h0);
    @(negedge clk); rst = 1'b0;
    last_out = '0;
    run_prog(0, 0, 0, "after_rst");

    for (int it = 0; it < 6; it++) begin
      bit lp;
      int sa;
      for (int i = 0; i < DEPTH; i++) write_word(i, rand_word(1));
      lp = 1'($urandom_range(0, 1));
      sa = lp ? $urandom_range(1, 30) : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0);
      run_prog(lp, sa, 0, $sformatf("rand%0d", it));
    end

`ifdef INSTR_SEQUENCER_STEP_MODE_EN
    write_word(0, 16'h1111);
    write_word(1, 16'h2222);
    write_word(2, 16'h3333);
    step_en = 1'b1; loop_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!issue_strobe && k < 20) begin @(negedge clk); k++; end
    check_eq("step first_word", {16'h0, opcode, opr1, opr2}, 32'h1111);
    any_strobe = 0;
    repeat (10) begin @(negedge clk); any_strobe |= issue_strobe; end
    check_eq("step paused_no_strobe", {31'h0, any_strobe}, 32'h0);
    check_eq("step paused_busy", {31'h0, busy}, 32'h1);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("step strobe", {31'h0, issue_strobe}, 32'h1);
    check_eq("step second_word", {16'h0, opcode, opr1, opr2}, 32'h2222);
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check_eq("step stop_done", {30'h0, busy, done}, 32'h1);
    step_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
